// File: rtl/perm3_seq_ctrl.sv
// rtl/perm3_seq_ctrl.sv - LFSR-driven burst sequencer around the 3-symbol permutation map

module randomPerm3Map (
    input  logic [5:0] X_all,
    input  logic [6:0] random,
    output logic [5:0] Y_all,
    output logic [2:0] idx
);

    always_comb begin
        if (random <= 7'd20)
            idx = 3'd0;
        else if (random <= 7'd41)
            idx = 3'd1;
        else if (random <= 7'd63)
            idx = 3'd2;
        else if (random <= 7'd84)
            idx = 3'd3;
        else if (random <= 7'd105)
            idx = 3'd4;
        else
            idx = 3'd5;
    end

    always_comb begin
        case (idx)
            3'd0:    Y_all = X_all;
            3'd1:    Y_all = {X_all[3:2], X_all[5:4], X_all[1:0]};
            3'd2:    Y_all = {X_all[5:4], X_all[1:0], X_all[3:2]};
            3'd3:    Y_all = {X_all[3:2], X_all[1:0], X_all[5:4]};
            3'd4:    Y_all = {X_all[1:0], X_all[5:4], X_all[3:2]};
            default: Y_all = {X_all[1:0], X_all[3:2], X_all[5:4]};
        endcase
    end

endmodule

module perm3_seq_ctrl #(
    parameter logic [6:0] SEED      = 7'h01,
    parameter bit         NO_REPEAT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] X_all,
    input  logic [7:0] count,
    output logic [5:0] Y_all,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [6:0] random
);

    // An all-zero seed would lock the LFSR, so fall back to 1.
    localparam logic [6:0] SEED_EFF = (SEED == 7'd0) ? 7'h01 : SEED;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        PRESENT
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] lfsr, lfsr_nxt;
    logic [5:0] x_reg, x_nxt;
    logic [7:0] remaining, rem_nxt;
    logic [2:0] prev_idx, prev_nxt;
    logic       have_prev, have_nxt;
    logic [5:0] y_nxt;
    logic       valid_nxt;
    logic       done_nxt;

    logic [5:0] map_y;
    logic [2:0] map_idx;

    randomPerm3Map u_map (
        .X_all  (x_reg),
        .random (lfsr),
        .Y_all  (map_y),
        .idx    (map_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED_EFF;
            x_reg     <= 6'd0;
            remaining <= 8'd0;
            prev_idx  <= 3'd0;
            have_prev <= 1'b0;
            Y_all     <= 6'd0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            x_reg     <= x_nxt;
            remaining <= rem_nxt;
            prev_idx  <= prev_nxt;
            have_prev <= have_nxt;
            Y_all     <= y_nxt;
            out_valid <= valid_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        x_nxt     = x_reg;
        rem_nxt   = remaining;
        prev_nxt  = prev_idx;
        have_nxt  = have_prev;
        y_nxt     = Y_all;
        valid_nxt = out_valid;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (count != 8'd0) begin
                        x_nxt     = X_all;
                        rem_nxt   = count;
                        have_nxt  = 1'b0;
                        state_nxt = DRAW;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            DRAW: begin
                // The LFSR steps on every draw, including rejected ones.
                lfsr_nxt = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                if (!(NO_REPEAT && have_prev && (map_idx == prev_idx))) begin
                    y_nxt     = map_y;
                    prev_nxt  = map_idx;
                    have_nxt  = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    rem_nxt   = remaining - 8'd1;
                    valid_nxt = 1'b0;
                    if (remaining == 8'd1) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = DRAW;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    assign busy   = (state != IDLE);
    assign random = lfsr;

endmodule

// File: tb/tb_perm3_seq_ctrl.sv
// tb/tb_perm3_seq_ctrl.sv - directed bench for perm3_seq_ctrl, repeat and no-repeat variants

module tb_perm3_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] X_all;
    logic [7:0] count;
    logic       out_ready;

    logic [5:0] y_rep, y_nr;
    logic       ov_rep, ov_nr;
    logic       busy_rep, busy_nr;
    logic       done_rep, done_nr;
    logic [6:0] rnd_rep, rnd_nr;

    int total = 0;
    int bad   = 0;

    perm3_seq_ctrl #(.SEED(7'h01), .NO_REPEAT(1'b0)) u_rep (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .X_all     (X_all),
        .count     (count),
        .Y_all     (y_rep),
        .out_valid (ov_rep),
        .out_ready (out_ready),
        .busy      (busy_rep),
        .done      (done_rep),
        .random    (rnd_rep)
    );

    perm3_seq_ctrl #(.SEED(7'h01), .NO_REPEAT(1'b1)) u_nr (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .X_all     (X_all),
        .count     (count),
        .Y_all     (y_nr),
        .out_valid (ov_nr),
        .out_ready (out_ready),
        .busy      (busy_nr),
        .done      (done_nr),
        .random    (rnd_nr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; X_all = 6'h00; count = 8'd0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_y",     y_rep,    6'h00);
        chk("rst_ov",    ov_rep,   1'b0);
        chk("rst_busy",  busy_rep, 1'b0);
        chk("rst_done",  done_rep, 1'b0);
        chk("rst_rnd",   rnd_rep,  7'd1);
        chk("rst_rnd_nr", rnd_nr,  7'd1);

        // Basic burst on both variants, count=3, X=6'h24
        X_all = 6'h24; count = 8'd3; start = 1'b1;
        step();                                         // cycle 1
        start = 1'b0;
        chk("c1_busy",    busy_rep, 1'b1);
        chk("c1_ov",      ov_rep,   1'b0);
        chk("c1_busy_nr", busy_nr,  1'b1);
        step();                                         // cycle 2
        chk("c2_ov",     ov_rep, 1'b1);
        chk("c2_y",      y_rep,  6'h24);
        chk("c2_rnd",    rnd_rep, 7'd2);
        chk("c2_ov_nr",  ov_nr,  1'b1);
        chk("c2_y_nr",   y_nr,   6'h24);
        step();                                         // cycle 3
        chk("c3_ov",     ov_rep, 1'b0);
        chk("c3_ov_nr",  ov_nr,  1'b0);
        step();                                         // cycle 4
        chk("c4_ov",     ov_rep, 1'b1);
        chk("c4_y",      y_rep,  6'h24);
        chk("c4_ov_nr",  ov_nr,  1'b0);
        chk("c4_rnd_nr", rnd_nr, 7'd4);
        step();                                         // cycle 5
        step();                                         // cycle 6
        chk("c6_ov",     ov_rep,   1'b1);
        chk("c6_y",      y_rep,    6'h24);
        chk("c6_done",   done_rep, 1'b0);
        step();                                         // cycle 7
        chk("c7_done",   done_rep, 1'b1);
        chk("c7_busy",   busy_rep, 1'b0);
        chk("c7_ov",     ov_rep,   1'b0);
        chk("c7_rnd",    rnd_rep,  7'd8);
        chk("c7_rnd_nr", rnd_nr,   7'd32);
        chk("c7_ov_nr",  ov_nr,    1'b0);
        step();                                         // cycle 8
        chk("c8_done",   done_rep, 1'b0);
        chk("c8_ov_nr",  ov_nr,    1'b1);
        chk("c8_y_nr",   y_nr,     6'h18);
        chk("c8_rnd_nr", rnd_nr,   7'd65);
        step();                                         // cycle 9
        chk("c9_ov_nr",  ov_nr, 1'b0);
        step();                                         // cycle 10
        chk("c10_ov_nr",   ov_nr,   1'b1);
        chk("c10_y_nr",    y_nr,    6'h12);
        chk("c10_done_nr", done_nr, 1'b0);
        step();                                         // cycle 11
        chk("c11_done_nr", done_nr, 1'b1);
        chk("c11_busy_nr", busy_nr, 1'b0);
        chk("c11_rnd_nr",  rnd_nr,  7'd3);
        step();                                         // cycle 12
        chk("c12_done_nr", done_nr, 1'b0);

        // Backpressure: hold out_ready low for 5 cycles in PRESENT
        X_all = 6'h1B; count = 8'd1; start = 1'b1; out_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        chk("bp_ov0",  ov_rep,  1'b1);
        chk("bp_y0",   y_rep,   6'h1B);
        chk("bp_rnd0", rnd_rep, 7'd16);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ov_hold",   ov_rep,   1'b1);
            chk("bp_y_hold",    y_rep,    6'h1B);
            chk("bp_rnd_hold",  rnd_rep,  7'd16);
            chk("bp_done_hold", done_rep, 1'b0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_done", done_rep, 1'b1);
        chk("bp_ov",   ov_rep,   1'b0);
        chk("bp_busy", busy_rep, 1'b0);
        step();

        // count=0: immediate done, nothing emitted, LFSR untouched
        count = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("z_done", done_rep, 1'b1);
        chk("z_ov",   ov_rep,   1'b0);
        chk("z_rnd",  rnd_rep,  7'd16);
        step();
        chk("z_done2", done_rep, 1'b0);
        chk("z_ov2",   ov_rep,   1'b0);
        chk("z_busy2", busy_rep, 1'b0);

        // start while busy is ignored; x_reg stays at the latched triple
        X_all = 6'h24; count = 8'd2; start = 1'b1;
        step();                                         // cycle 1 (DRAW)
        X_all = 6'h3F; start = 1'b1;
        step();                                         // cycle 2
        start = 1'b0;
        chk("sb_ov1",  ov_rep,  1'b1);
        chk("sb_y1",   y_rep,   6'h24);
        chk("sb_rnd1", rnd_rep, 7'd32);
        step();                                         // cycle 3
        chk("sb_ov_gap", ov_rep, 1'b0);
        step();                                         // cycle 4
        chk("sb_ov2", ov_rep, 1'b1);
        chk("sb_y2",  y_rep,  6'h18);
        step();                                         // cycle 5
        chk("sb_done", done_rep, 1'b1);
        chk("sb_busy", busy_rep, 1'b0);

        // start in the done cycle is accepted
        X_all = 6'h24; count = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("dd_busy", busy_rep, 1'b1);
        chk("dd_done", done_rep, 1'b0);
        step();
        chk("dd_ov",  ov_rep,  1'b1);
        chk("dd_y",   y_rep,   6'h12);
        chk("dd_rnd", rnd_rep, 7'd3);

        // Reset mid-burst from PRESENT
        rst = 1'b1; out_ready = 1'b0;
        step();
        rst = 1'b0;
        chk("mr_ov",   ov_rep,   1'b0);
        chk("mr_busy", busy_rep, 1'b0);
        chk("mr_y",    y_rep,    6'h00);
        chk("mr_rnd",  rnd_rep,  7'd1);
        chk("mr_done", done_rep, 1'b0);
        step();
        chk("mr_done2", done_rep, 1'b0);
        chk("mr_busy2", busy_rep, 1'b0);
        chk("mr_rnd2",  rnd_rep,  7'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/perm3_seq_ctrl.md
# perm3_seq_ctrl

Sequencing controller for the 3-symbol random permutation datapath. It owns a 7-bit LFSR that supplies the `random` select to an internal `randomPerm3Map` instance. On a start command it emits a burst of `count` permuted 6-bit words over a valid/ready handshake. An optional no-repeat mode redraws whenever a permutation would match the previous one. It sits between the random-sequence front end and any consumer of permuted symbol triples.

## Interface
- `SEED`, 7'h01: LFSR reset value. A value of 0 is illegal; the block substitutes 7'h01.
- `NO_REPEAT`, 0: when 1, two consecutive emitted words within one burst never use the same permutation index.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a burst. Sampled only in IDLE.
- `X_all`  in  6  symbol triple {s2,s1,s0}, 2 bits each. Latched at accepted start.
- `count`  in  8  burst length in words. Latched at accepted start.
- `Y_all`  out  6  permuted word, registered.
- `out_valid`  out  1  `Y_all` holds a word for the consumer.
- `out_ready`  in  1  consumer accepts the word.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a burst ends.
- `random`  out  7  current LFSR value (debug).

## Operation
- LFSR (Fibonacci, x^7+x^6+1):
  - next = {lfsr[5:0], lfsr[6]^lfsr[5]}; period 127; never 0.
  - Advances only on cycles spent in DRAW.
- Permutation index, from the current LFSR value:
  - 0 for 0–20, 1 for 21–41, 2 for 42–63, 3 for 64–84, 4 for 85–105, 5 for 106–127.
  - Must match the bucket boundaries of `randomPerm3Map`.
  - Y mapping per index:
    - 0: identity.
    - 1: Y[5:4]=X[3:2], Y[3:2]=X[5:4].
    - 2: swap the low two symbols.
    - 3: Y[3:2]=X[1:0], Y[5:4]=X[3:2], Y[1:0]=X[5:4].
    - 4: Y[5:4]=X[1:0], Y[1:0]=X[3:2], Y[3:2]=X[5:4].
    - 5: swap s0 and s2.
- FSM states: IDLE, DRAW, PRESENT.
- IDLE:
  - `start` with `count`≠0: latch X_all and count into x_reg and remaining, clear have_prev, go to DRAW.
  - `start` with `count`=0: pulse `done` next cycle, stay in IDLE.
- DRAW:
  - Compute idx from the current LFSR value and advance the LFSR.
  - If NO_REPEAT, have_prev, and idx equals prev_idx: reject and stay in DRAW.
  - Otherwise register `Y_all`=map(x_reg, lfsr), set prev_idx=idx and have_prev=1, set `out_valid`, go to PRESENT.
- PRESENT:
  - Hold `Y_all` and `out_valid`.
  - On `out_ready`, decrement remaining.
  - If remaining was 1: clear `out_valid`, go to IDLE, pulse `done`.
  - Otherwise clear `out_valid` and go to DRAW.
- `start` is ignored while `busy`. x_reg and count stay frozen for the whole burst.
- LFSR state persists across bursts; only `rst` reloads SEED.

## Timing
- Reset values: `Y_all`=0, `out_valid`=0, `busy`=0, `done`=0, `random`=SEED, state IDLE, have_prev=0.
- `rst` takes effect at the next edge from any state, including mid-burst. The word in flight is discarded and no `done` is issued.
- Latency, start accepted at cycle 0:
  - DRAW at cycle 1.
  - First `out_valid` at cycle 2 when there is no rejection; each rejection adds 1 cycle.
- Peak throughput is 1 word per 2 cycles (PRESENT→DRAW→PRESENT) with `out_ready` held high.
- `out_ready` low: `Y_all` and `out_valid` are held indefinitely and the LFSR does not advance.
- `done` asserts in the cycle after the final handshake and lasts exactly 1 cycle. `busy` is low in that same cycle.
- A `start` in the same cycle as `done` is accepted.

## Test plan
- SEED=1, NO_REPEAT=0, X_all=6'h24, count=3, `out_ready`=1, start at cycle 0:
  - `out_valid` at cycles 2, 4, 6, each with `Y_all`=6'h24 (draws 1, 2, 4 → idx 0).
  - `done` at cycle 7; `random`=8 afterwards.
- Same setup with NO_REPEAT=1, count=3:
  - Draw 1 is accepted → 6'h24.
  - Draws 2, 4, 8, 16 are rejected; draw 32 (idx 1) is accepted → 6'h18.
  - Draw 65 (idx 3) is accepted → 6'h12.
  - `done` follows the third handshake.
- Backpressure: hold `out_ready`=0 for 5 cycles while in PRESENT.
  - `Y_all`, `out_valid`=1 and `random` are all stable.
  - Raising `out_ready` completes the handshake in that cycle.
- count=0 with start at cycle 0: `done`=1 at cycle 1, `out_valid` never asserts, `random` unchanged.
- Pulse `start` with a different X_all while busy: the burst continues with the original data.
- Assert `rst` in PRESENT: on the next cycle `out_valid`=0, `busy`=0, `Y_all`=0, `random`=SEED, and no `done` is issued.
